// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst drain of several FIFO read ports
// into one tagged output stream with almost-full backpressure.
module fifo_drain_arbiter #(
  parameter int NUM_FIFOS  = 4,
  parameter int WIDTH      = 512,
  parameter int LOG2_DEPTH = 5,
  parameter int MAX_BURST  = 8,
  localparam int SW = (NUM_FIFOS > 2) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*LOG2_DEPTH-1:0] fifo_count,
  output logic [NUM_FIFOS-1:0]            fifo_re,
  input  logic [NUM_FIFOS-1:0]            fifo_rvalid,
  input  logic [NUM_FIFOS*WIDTH-1:0]      fifo_rdata,
  input  logic                            out_almostfull,
  output logic                            out_valid,
  output logic [WIDTH-1:0]                out_data,
  output logic [SW-1:0]                   out_src,
  output logic                            out_last,
  output logic [31:0]                     beat_count,
  output logic                            busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [SW-1:0]   grant;
  logic [SW-1:0]   last_grant;
  logic [SW-1:0]   next_grant;
  logic [SW-1:0]   cand;
  logic            found;
  logic [CW-1:0]   burst_cnt;
  logic            tag_valid;
  logic            tag_last;
  logic [SW-1:0]   tag_src;
  logic            rd;
  logic            rd_last;
  logic            beat;

  logic [LOG2_DEPTH-1:0] cnt_a  [NUM_FIFOS];
  logic [WIDTH-1:0]      data_a [NUM_FIFOS];

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_unpack
    assign cnt_a[i]  = fifo_count[i*LOG2_DEPTH +: LOG2_DEPTH];
    assign data_a[i] = fifo_rdata[i*WIDTH +: WIDTH];
  end

  // count==0 while non-empty means a full FIFO, so only count==1 ends early
  always_comb begin
    rd = (state == BURST) && !fifo_empty[grant]
      && !out_almostfull;
    rd_last = (burst_cnt == CW'(MAX_BURST - 1))
      || (cnt_a[grant] == LOG2_DEPTH'(1)
      && !fifo_empty[grant]);
    fifo_re = '0;
    if (rd) fifo_re[grant] = 1'b1;
  end

  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      cand = SW'((int'(last_grant) + k) % NUM_FIFOS);
      if (!found && !fifo_empty[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  assign beat = tag_valid && fifo_rvalid[tag_src];
  assign busy = (state == BURST) || tag_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SW'(NUM_FIFOS - 1);
      burst_cnt  <= '0;
      tag_valid  <= 1'b0;
      tag_src    <= '0;
      tag_last   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_last   <= 1'b0;
      beat_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && found) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            burst_cnt  <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (rd) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (rd_last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // one read in flight at most: rvalid returns the next cycle
      tag_valid <= rd;
      if (rd) begin
        tag_src  <= grant;
        tag_last <= rd_last;
      end
      out_valid <= beat;
      out_last  <= beat && tag_last;
      if (beat) begin
        out_data   <= data_a[tag_src];
        out_src    <= tag_src;
        beat_count <= beat_count + 32'd1;
      end
    end
  end

endmodule
